if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC, issues
//   one request at a time to instruction memory, holds the returned instruction in a
//   one-entry output slot with valid/ready handshake, and redirects on branch/jump.
//   A response belonging to an abandoned (redirected) request is discarded.
// PARAMETERS
//   ADDR_W    32  PC / memory address width
//   INSTR_W   32  instruction width
//   RESET_PC  0   PC value loaded on reset
//   PC_STEP   4   PC increment per sequential fetch
// PORTS
//   clk          in   1        single clock; all state updates on posedge clk
//   rst          in   1        synchronous, active-high reset
//   redirect     in   1        branch/jump taken; flush fetch, restart at redirect_pc
//   redirect_pc  in   ADDR_W   redirect target
//   imem_req     out  1        request strobe (one cycle per request)
//   imem_addr    out  ADDR_W   request address (= pc while imem_req=1)
//   imem_rvalid  in   1        response valid (>=1 cycle after request)
//   imem_rdata   in   INSTR_W  response instruction
//   out_valid    out  1        output slot holds an instruction
//   out_ready    in   1        IF/ID accepts (deasserted by hazard unit on stall)
//   out_instr    out  INSTR_W  fetched instruction
//   out_pc       out  ADDR_W   address of out_instr
//   out_pc_next  out  ADDR_W   out_pc + PC_STEP (link/branch base)
// BEHAVIOUR
//   - Reset (sync): pc<=RESET_PC, state<=FETCH, out_valid<=0, out_instr<=0, out_pc<=0.
//     imem_req is 0 in the reset cycle. Instruction memory shares rst, so no stale
//     response arrives after reset; any rvalid seen in FETCH is ignored.
//   - Transfer occurs on a cycle with out_valid && out_ready; slot clears at that edge
//     unless refilled. slot_free = !out_valid || out_ready.
//   - States: FETCH, WAIT, DISCARD. Only one request outstanding at any time.
//   - FETCH: imem_req = slot_free && !redirect (combinational), imem_addr = pc.
//     redirect: pc<=redirect_pc, stay FETCH. Request issued: ->WAIT. Else stay.
//   - WAIT: imem_req=0.
//       redirect (with or without imem_rvalid same cycle): data dropped, pc<=redirect_pc;
//       ->FETCH if imem_rvalid this cycle, else ->DISCARD.
//       imem_rvalid, no redirect: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1,
//       pc<=pc+PC_STEP, ->FETCH. Slot is guaranteed empty (issue required slot_free).
//   - DISCARD: imem_req=0. imem_rvalid: drop data, ->FETCH. redirect: pc<=redirect_pc
//     (latest target wins), stay DISCARD until the pending response is dropped.
//   - Redirect in any state clears out_valid at that edge (slot is wrong-path). A
//     transfer in the redirect cycle still counts; IF/ID flush is the hazard unit's job.
//   - Arithmetic: pc+PC_STEP and out_pc_next are modulo 2^ADDR_W (wrap, no flag).
//     redirect_pc is used unaligned/unchecked.
//   - Throughput with 1-cycle memory and out_ready=1: one instruction per 2 cycles.
//   - Stall (out_ready=0): slot and out_* hold stable; no new request is issued.
// TESTING
//   1 Reset release, RESET_PC=0, 1-cycle mem, out_ready=1 -> imem_addr 0,4,8 on
//     cycles 1,3,5; out_valid with out_pc 0,4,8 and out_pc_next 4,8,12.
//   2 Stall: hold out_ready=0 for 5 cycles with instr@8 in slot -> out_* stable,
//     imem_req=0; release -> next request addr 12 in the same cycle.
//   3 Redirect during WAIT, mem latency 3 -> state DISCARD, returned word never
//     appears on out_instr; next imem_addr = redirect_pc (e.g. 0x100).
//   4 Redirect coincident with imem_rvalid -> data dropped, next cycle imem_req with
//     addr=redirect_pc; out_valid=0 after the edge.
//   5 Wrap: RESET_PC=0xFFFF_FFFC -> out_pc_next=0, second fetch addr 0x0000_0000.
//   6 rst asserted while in WAIT with out_valid=1 -> next cycle out_valid=0,
//     imem_req=0; following cycle imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and the IF/ID register.
//
// Handshakes:
//   imem: the fetch stage raises imem_req for exactly one cycle with imem_addr;
//         memory answers later with a single-cycle imem_rvalid and imem_rdata.
//         At most one request is outstanding, so there is no request-side ready.
//   out:  out_valid/out_ready; a transfer happens on any posedge where both are 1.
//         While out_valid=1 and out_ready=0, out_instr/out_pc/out_pc_next hold
//         stable until the transfer (a redirect may still withdraw the slot).
interface if_fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;

    // Fetch-stage side
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
        input  imem_rvalid, imem_rdata, out_ready
    );

    // Memory / IF-ID side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
        output imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight,
// parks the returned instruction in a one-entry output slot and restarts at
// redirect_pc on branch/jump. Responses to abandoned requests are dropped.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    if_fetch_stage_if.master   fetch_if,
    output logic [1:0]         dbg_state_o
);

    // FETCH: may issue; WAIT: response pending for current pc;
    // DISCARD: response pending for an abandoned request.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic               out_valid_q, out_valid_d;
    logic               slot_free;
    logic               transfer;
    logic               req;

    // The slot can take a new word if empty or if it drains at this edge.
    assign transfer  = out_valid_q && fetch_if.out_ready;
    assign slot_free = !out_valid_q || fetch_if.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (!redirect && slot_free) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // Response for the old path still owed unless it is here now.
                    state_d = fetch_if.imem_rvalid ? S_FETCH : S_DISCARD;
                end else if (fetch_if.imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (fetch_if.imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Output logic: request strobe, suppressed during reset
    always_comb begin
        req = 1'b0;
        if (!rst && state_q == S_FETCH && slot_free && !redirect) begin
            req = 1'b1;
        end
    end

    // Datapath next-state: PC and output slot
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q && !transfer;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect) begin
            // Slot content is wrong-path; any response this cycle is dropped.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
        end else if (state_q == S_WAIT && fetch_if.imem_rvalid) begin
            out_instr_d = fetch_if.imem_rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign fetch_if.imem_req    = req;
    assign fetch_if.imem_addr   = pc_q;
    assign fetch_if.out_valid   = out_valid_q;
    assign fetch_if.out_instr   = out_instr_q;
    assign fetch_if.out_pc      = out_pc_q;
    assign fetch_if.out_pc_next = out_pc_q + PC_STEP;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: DUT a (RESET_PC=0) runs the directed sequence,
// DUT b (RESET_PC=0xFFFF_FFFC) exercises PC wrap alongside it.
module tb_if_fetch_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [1:0]  state_a, state_b;

    if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) ifa ();
    if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) ifb ();

    if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_if    (ifa),
        .dbg_state_o (state_a)
    );

    if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(WRAP_PC), .PC_STEP(32'd4)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .fetch_if    (ifb),
        .dbg_state_o (state_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] req_q[$];     // expected imem_addr of each request, dut a
    logic [31:0] exp_q[$];     // expected out_pc of each transfer, dut a
    logic [31:0] b_req_q[$];
    logic [31:0] b_exp_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory models ----------------
    int          mem_lat = 1;
    int          a_cnt = 0;
    logic [31:0] a_addr = '0;
    logic        b_pend = 1'b0;
    logic [31:0] b_addr = '0;

    initial begin
        ifa.imem_rvalid = 1'b0;
        ifa.imem_rdata  = '0;
        ifb.imem_rvalid = 1'b0;
        ifb.imem_rdata  = '0;
        ifb.out_ready   = 1'b1;
    end

    // Memory for dut a: variable latency, cleared by the shared reset
    always @(negedge clk) begin
        if (rst) begin
            ifa.imem_rvalid = 1'b0;
            a_cnt = 0;
        end else begin
            ifa.imem_rvalid = 1'b0;
            if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    ifa.imem_rvalid = 1'b1;
                    ifa.imem_rdata  = instr_of(a_addr);
                end
            end
            if (ifa.imem_req) begin
                a_cnt  = mem_lat;
                a_addr = ifa.imem_addr;
            end
        end
    end

    // Memory for dut b: fixed 1-cycle latency
    always @(negedge clk) begin
        if (rst) begin
            ifb.imem_rvalid = 1'b0;
            b_pend = 1'b0;
        end else begin
            ifb.imem_rvalid = b_pend;
            ifb.imem_rdata  = instr_of(b_addr);
            b_pend = ifb.imem_req;
            if (ifb.imem_req) b_addr = ifb.imem_addr;
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.imem_req) begin
                if (req_q.size() == 0) chk("a_req_unexpected", ifa.imem_addr, 32'hxxxx_xxxx);
                else chk("a_req_addr", ifa.imem_addr, req_q.pop_front());
            end
            if (ifa.out_valid && ifa.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("a_xfer_unexpected", ifa.out_pc, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("a_out_pc", ifa.out_pc, e);
                    chk("a_out_instr", ifa.out_instr, instr_of(e));
                    chk("a_out_pc_next", ifa.out_pc_next, e + 32'd4);
                end
            end
            if (ifb.imem_req && b_req_q.size() != 0) chk("b_req_addr", ifb.imem_addr, b_req_q.pop_front());
            if (ifb.out_valid && ifb.out_ready && b_exp_q.size() != 0) begin
                logic [31:0] e;
                e = b_exp_q.pop_front();
                chk("b_out_pc", ifb.out_pc, e);
                chk("b_out_instr", ifb.out_instr, instr_of(e));
                chk("b_out_pc_next", ifb.out_pc_next, e + 32'd4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        ifa.out_ready = 1'b1;
        req_q.push_back(32'h0);  req_q.push_back(32'h4);  req_q.push_back(32'h8);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
        b_req_q.push_back(WRAP_PC); b_req_q.push_back(32'h0);
        b_exp_q.push_back(WRAP_PC); b_exp_q.push_back(32'h0);

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_req", 32'(ifa.imem_req), 32'd0);
        chk("rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_out_pc", ifa.out_pc, 32'h0);
        step();
        rst = 1'b0;

        // Test 1: back-to-back fetch, one instruction per two cycles
        @(negedge clk);
        chk("t1_first_req", 32'(ifa.imem_req), 32'd1);
        chk("t1_first_addr", ifa.imem_addr, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ifa.out_valid && ifa.out_pc == 32'h8) && n < 20);
        chk("t1_cycles_to_pc8", n, 6);
        ifa.out_ready = 1'b0;

        // Test 2: stall holds slot and blocks requests
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_valid", 32'(ifa.out_valid), 32'd1);
            chk("t2_pc", ifa.out_pc, 32'h8);
            chk("t2_instr", ifa.out_instr, instr_of(32'h8));
            chk("t2_pc_next", ifa.out_pc_next, 32'hC);
            chk("t2_no_req", 32'(ifa.imem_req), 32'd0);
            step();
        end
        mem_lat = 3;
        req_q.push_back(32'hC);
        ifa.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_release_req", 32'(ifa.imem_req), 32'd1);
        chk("t2_release_addr", ifa.imem_addr, 32'hC);

        // Test 3: redirect while waiting, then again while discarding
        step();
        @(negedge clk);
        chk("t3_wait", 32'(state_a), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h180;
        step();
        chk("t3_discard", 32'(state_a), 32'd2);
        redirect_pc = 32'h100;
        mem_lat = 1;
        req_q.push_back(32'h100);
        step();
        redirect = 1'b0;
        chk("t3_discard_hold", 32'(state_a), 32'd2);
        chk("t3_slot_empty", 32'(ifa.out_valid), 32'd0);
        step();
        chk("t3_back_fetch", 32'(state_a), 32'd0);
        @(negedge clk);
        chk("t3_refetch_addr", ifa.imem_addr, 32'h100);

        // Test 4: redirect coincident with the response
        step();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        req_q.push_back(32'h200);
        exp_q.push_back(32'h200);
        step();
        redirect = 1'b0;
        chk("t4_valid_cleared", 32'(ifa.out_valid), 32'd0);
        chk("t4_state", 32'(state_a), 32'd0);
        @(negedge clk);
        chk("t4_req", 32'(ifa.imem_req), 32'd1);
        chk("t4_addr", ifa.imem_addr, 32'h200);
        req_q.push_back(32'h204);
        step();
        step();
        @(negedge clk);
        chk("t4_refill_valid", 32'(ifa.out_valid), 32'd1);

        // Test 6: reset while a response is pending
        step();
        chk("t6_in_wait", 32'(state_a), 32'd1);
        rst = 1'b1;
        ifa.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_rst_req", 32'(ifa.imem_req), 32'd0);
        req_q.push_back(32'h0);
        step();
        rst = 1'b0;
        chk("t6_valid", 32'(ifa.out_valid), 32'd0);
        chk("t6_state", 32'(state_a), 32'd0);
        @(negedge clk);
        chk("t6_req", 32'(ifa.imem_req), 32'd1);
        chk("t6_addr", ifa.imem_addr, 32'h0);
        step();
        step();
        @(negedge clk);
        chk("t6_fill_valid", 32'(ifa.out_valid), 32'd1);
        chk("t6_fill_pc", ifa.out_pc, 32'h0);
        chk("t6_fill_instr", ifa.out_instr, instr_of(32'h0));
        chk("t6_stall_no_req", 32'(ifa.imem_req), 32'd0);

        // Every expected event must have been observed
        repeat (2) step();
        chk("a_req_q_drained", req_q.size(), 0);
        chk("a_exp_q_drained", exp_q.size(), 0);
        chk("b_req_q_drained", b_req_q.size(), 0);
        chk("b_exp_q_drained", b_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
